// File: rtl/epd_pkg.sv
// Shared constants, state encoding and field-legality helper for the Ethernet packet detector.
package epd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t PRE  = 3'd1;
  localparam state_t DST  = 3'd2;
  localparam state_t SRC  = 3'd3;
  localparam state_t TL   = 3'd4;
  localparam state_t PAY  = 3'd5;
  localparam state_t DROP = 3'd6;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] LEN_MAX       = 16'h05DC;
  localparam logic [15:0] TYPE_MIN      = 16'h0600;
  localparam int          MIN_FRAME     = 64;
  localparam int          MAX_FRAME     = 1518;

  // Lengths up to LEN_MAX and EtherTypes from TYPE_MIN are legal; the gap between is not.
  function automatic logic tl_legal(input logic [15:0] v);
    return (v <= LEN_MAX) || (v >= TYPE_MIN);
  endfunction

endpackage

// File: rtl/epd.sv
// Byte-wide Ethernet frame parser: validates header fields and frame size,
// and counts fully valid frames in a wrapping counter.
module epd #(
  parameter int MIN_FRAME = epd_pkg::MIN_FRAME,
  parameter int MAX_FRAME = epd_pkg::MAX_FRAME,
  parameter int CNT_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             control,
  output logic             preamble_valid,
  output logic             dst_addr_valid,
  output logic             src_addr_valid,
  output logic             type_length_valid,
  output logic             packet_size_valid,
  output logic [CNT_W-1:0] valid_packet_counter
);
  import epd_pkg::*;

  localparam logic [10:0] MIN_B = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_B = 11'(MAX_FRAME);

  state_t      state;
  logic [2:0]  idx;       // byte index within the current header field
  logic [10:0] byte_cnt;  // DST through end of frame, saturating
  logic [39:0] sh;        // previous five bytes; the current byte completes a field

  logic size_ok;
  logic frame_ok;
  assign size_ok  = (byte_cnt >= MIN_B) && (byte_cnt <= MAX_B);
  assign frame_ok = preamble_valid && dst_addr_valid && src_addr_valid &&
                    type_length_valid && size_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      idx                  <= '0;
      byte_cnt             <= '0;
      sh                   <= '0;
      preamble_valid       <= 1'b0;
      dst_addr_valid       <= 1'b0;
      src_addr_valid       <= 1'b0;
      type_length_valid    <= 1'b0;
      packet_size_valid    <= 1'b0;
      valid_packet_counter <= '0;
    end else begin
      if (control && (state == DST || state == SRC || state == TL || state == PAY) &&
          byte_cnt != 11'h7FF)
        byte_cnt <= byte_cnt + 11'd1;

      case (state)
        IDLE: if (control) begin
          preamble_valid    <= 1'b0;
          dst_addr_valid    <= 1'b0;
          src_addr_valid    <= 1'b0;
          type_length_valid <= 1'b0;
          packet_size_valid <= 1'b0;
          byte_cnt          <= '0;
          idx               <= 3'd1;
          state             <= (data == PREAMBLE_BYTE) ? PRE : DROP;
        end
        PRE: begin
          if (!control) state <= IDLE;
          else if (idx == 3'd7) begin
            if (data == SFD_BYTE) begin
              preamble_valid <= 1'b1;
              idx            <= '0;
              state          <= DST;
            end else state <= DROP;
          end else if (data != PREAMBLE_BYTE) state <= DROP;
          else idx <= idx + 3'd1;
        end
        DST, SRC: begin
          if (!control) state <= IDLE;
          else begin
            sh <= {sh[31:0], data};
            if (idx == 3'd5) begin
              if (state == DST) dst_addr_valid <= ({sh, data} != '0);
              else              src_addr_valid <= ({sh, data} != '0);
              idx   <= '0;
              state <= (state == DST) ? SRC : TL;
            end else idx <= idx + 3'd1;
          end
        end
        TL: begin
          if (!control) state <= IDLE;
          else if (idx == 3'd0) begin
            sh  <= {sh[31:0], data};
            idx <= 3'd1;
          end else begin
            type_length_valid <= tl_legal({sh[7:0], data});
            idx               <= '0;
            state             <= PAY;
          end
        end
        PAY: if (!control) begin
          packet_size_valid <= size_ok;
          if (frame_ok) valid_packet_counter <= valid_packet_counter + CNT_W'(1);
          state <= IDLE;
        end
        DROP: if (!control) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epd.sv
// Randomized scoreboard bench for epd: a frame-level model predicts flags and
// counter, and a negedge monitor compares them at the predicted cycles.
module tb_epd;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       control = 1'b0;
  logic       preamble_valid, dst_addr_valid, src_addr_valid;
  logic       type_length_valid, packet_size_valid;
  logic [3:0] valid_packet_counter;

  epd #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .data(data), .control(control),
    .preamble_valid(preamble_valid), .dst_addr_valid(dst_addr_valid),
    .src_addr_valid(src_addr_valid), .type_length_valid(type_length_valid),
    .packet_size_valid(packet_size_valid),
    .valid_packet_counter(valid_packet_counter)
  );

  always #5 clock = ~clock;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         cyc;
    logic [4:0] flags;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   exp_cnt = 0;

  always @(posedge clock) cyc++;

  // Monitor: compare whenever the head expectation is due this cycle.
  always @(negedge clock) begin
    exp_t       e;
    logic [8:0] got;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      checks++;
      $display("FAIL %s: expectation for cycle %0d was never reached", e.name, e.cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e   = sbq.pop_front();
      got = {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
             packet_size_valid, valid_packet_counter};
      checks++;
      if (got === {e.flags, e.cnt}) passes++;
      else $display("FAIL %s @cyc %0d: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                    e.name, cyc, got[8:4], got[3:0], e.flags, e.cnt);
    end
  end

  task automatic push(input int stamp, input logic [4:0] f, input string nm);
    exp_t e;
    e.cyc = stamp; e.flags = f; e.cnt = 4'(exp_cnt % 16); e.name = nm;
    sbq.push_back(e);
  endtask

  // Frame-level reference: flags {pre, dst, src, tl, size} from the bytes seen while control=1.
  function automatic logic [4:0] model(input bq_t f);
    int          n = f.size();
    logic        pre, dst, src, tl, sz;
    logic [15:0] v;
    pre = (n >= 8);
    for (int i = 0; i < 7 && i < n; i++) if (f[i] != 8'h55) pre = 1'b0;
    if (n >= 8 && f[7] != 8'hD5) pre = 1'b0;
    if (!pre) return 5'b0;
    dst = 1'b0; src = 1'b0;
    if (n >= 14) for (int i = 8; i < 14; i++) if (f[i] != 0) dst = 1'b1;
    if (n >= 20) for (int i = 14; i < 20; i++) if (f[i] != 0) src = 1'b1;
    tl = 1'b0;
    if (n >= 22) begin
      v  = {f[20], f[21]};
      tl = (v <= 16'd1500) || (v >= 16'd1536);
    end
    sz = (n >= 22) && (n - 8 >= 64) && (n - 8 <= 1518);
    return {pre, dst, src, tl, sz};
  endfunction

  function automatic bq_t build(input logic [47:0] d, input logic [47:0] s,
                                input logic [15:0] t, input int total);
    bq_t q;
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) q.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(s[i*8 +: 8]);
    q.push_back(t[15:8]);
    q.push_back(t[7:0]);
    for (int i = 14; i < total; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic send(input bq_t f, input int ifg, input string nm);
    logic [4:0] fl;
    int         stamp;
    foreach (f[i]) begin
      @(negedge clock);
      data = f[i]; control = 1'b1;
    end
    @(negedge clock);
    control = 1'b0; data = 8'($urandom);
    fl = model(f);
    if (&fl) exp_cnt++;
    stamp = cyc + 1;
    for (int k = 0; k < ifg; k++) push(stamp + k, fl, nm);
    repeat (ifg - 1) @(negedge clock);
  endtask

  localparam logic [47:0] DA = 48'h010203040506;
  localparam logic [47:0] SA = 48'hFFFEFDFCFBFA;

  initial begin
    bq_t        f;
    logic [47:0] d, s;
    logic [15:0] t;
    int          budget;

    repeat (2) @(negedge clock);
    push(cyc + 1, 5'b0, "reset_state");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic frame: 49x 0x55 then 0xFF payload.
    f = build(DA, SA, 16'h0800, 14);
    repeat (49) f.push_back(8'h55);
    f.push_back(8'hFF);
    send(f, 1, "basic_frame");

    f = build(DA, SA, 16'h0800, 64);
    while (f.size() > 20) void'(f.pop_back());
    send(f, 3, "abort_before_tl");
    send(build(DA, SA, 16'h0800, 64), 1, "valid_after_ifg3");

    f = build(DA, SA, 16'h0800, 64);
    f[5] = 8'h54;
    send(f, 2, "bad_preamble");
    f = build(DA, SA, 16'h0800, 64);
    f[0] = 8'hAA;
    send(f, 1, "bad_first_byte");

    send(build(DA, SA, 16'h0800, 63),   1, "size_63");
    send(build(DA, SA, 16'h0800, 64),   1, "size_64");
    send(build(DA, SA, 16'h0800, 1519), 1, "size_1519");
    send(build(DA, SA, 16'h0800, 1518), 1, "size_1518");

    send(build(DA, SA, 16'h05DD, 80), 1, "tl_05dd");
    send(build(DA, SA, 16'h05DC, 80), 1, "tl_05dc");
    send(build(DA, SA, 16'h0600, 80), 1, "tl_0600");
    send(build(48'h0, SA, 16'h0800, 80), 1, "zero_dst");
    send(build(DA, 48'h0, 16'h0800, 80), 1, "zero_src");

    for (int i = 0; i < 16; i++) send(build(DA, SA, 16'h0800, 64), 1, "wrap16");

    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 5) == 0) ? 48'h0 : {16'($urandom), $urandom};
      s = ($urandom_range(0, 5) == 0) ? 48'h0 : {16'($urandom), $urandom};
      t = ($urandom_range(0, 2) == 0) ? 16'h05D0 + 16'($urandom_range(0, 63))
                                      : 16'($urandom);
      f = build(d, s, t, ($urandom_range(0, 2) == 0) ? $urandom_range(60, 68)
                                                     : $urandom_range(14, 120));
      if ($urandom_range(0, 7) == 0) begin
        int k = $urandom_range(0, 7);
        f[k] = f[k] ^ 8'($urandom_range(1, 255));
      end
      if ($urandom_range(0, 5) == 0) begin
        int keep = $urandom_range(1, 22);
        while (f.size() > keep) void'(f.pop_back());
      end
      send(f, $urandom_range(1, 3), "random_frame");
    end

    // Reset in the middle of the payload.
    f = build(DA, SA, 16'h0800, 100);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      data = f[i]; control = 1'b1;
    end
    @(negedge clock);
    reset = 1'b1;
    exp_cnt = 0;
    push(cyc + 1, 5'b0, "reset_mid_payload");
    @(negedge clock);
    reset = 1'b0; control = 1'b0;
    push(cyc + 1, 5'b0, "after_reset_idle");
    send(build(DA, SA, 16'h0800, 64), 2, "valid_after_reset");

    budget = 0;
    while (sbq.size() > 0 && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    if (sbq.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
